// File: rtl/moving_average_n.sv
`default_nettype none
// ============================================================================
// Module      : moving_average_n
// Description : Moving-average filter with a selectable window depth. A
//               running sum is updated once per sample, so the cost per sample
//               does not depend on the depth. Supports round-half-up
//               rounding, warm-up tracking and a synchronous window clear.
// Revision    : 1.0 - initial release
// ============================================================================
module moving_average_n #(
    parameter int WIDTH      = 8,
    parameter int LOG2_DEPTH = 2,
    parameter int ROUND      = 0
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             enable_n,
    input  logic             clear,
    input  logic [WIDTH-1:0] X1,
    output logic [WIDTH-1:0] Z,
    output logic             Z_valid,
    output logic             full
);

    localparam int c_depth = 1 << LOG2_DEPTH;
    localparam int c_sw    = WIDTH + LOG2_DEPTH;

    localparam logic [0:0] c_st_fill = 1'b0;
    localparam logic [0:0] c_st_run  = 1'b1;

    localparam logic [LOG2_DEPTH:0] c_cnt_full = (LOG2_DEPTH + 1)'(c_depth);

    logic [WIDTH-1:0]      r_buf [c_depth];
    logic [LOG2_DEPTH-1:0] r_wr_ptr;
    logic [LOG2_DEPTH:0]   r_cnt;
    logic [c_sw-1:0]       r_sum;
    logic [0:0]            r_state;
    logic [WIDTH-1:0]      r_z;
    logic                  r_z_valid;

    logic                  w_accept;
    logic [WIDTH-1:0]      w_old;
    logic [c_sw-1:0]       w_sum_next;
    logic [LOG2_DEPTH:0]   w_cnt_next;
    logic                  w_fills;
    logic [WIDTH-1:0]      w_quot;

    assign w_accept   = ~enable_n;
    assign w_old      = r_buf[r_wr_ptr];
    // The sum always contains the outgoing sample, so the subtraction cannot underflow.
    assign w_sum_next = r_sum + {{LOG2_DEPTH{1'b0}}, X1} - {{LOG2_DEPTH{1'b0}}, w_old};
    assign w_cnt_next = r_cnt + 1'b1;
    assign w_fills    = (r_state == c_st_fill) && (w_cnt_next == c_cnt_full);

    generate
        if (ROUND != 0) begin : g_round
            localparam int c_half = 1 << (LOG2_DEPTH - 1);
            logic [c_sw:0] w_rsum;
            logic          w_unused_rnd;

            assign w_rsum       = {1'b0, w_sum_next} + (c_sw + 1)'(c_half);
            assign w_quot       = w_rsum[LOG2_DEPTH +: WIDTH];
            assign w_unused_rnd = ^{w_rsum[c_sw], w_rsum[LOG2_DEPTH-1:0]};
        end else begin : g_trunc
            logic w_unused_trn;

            assign w_quot       = w_sum_next[LOG2_DEPTH +: WIDTH];
            assign w_unused_trn = ^w_sum_next[LOG2_DEPTH-1:0];
        end
    endgenerate

    always_ff @(posedge Clk) begin
        if (Rst || clear) begin
            r_buf     <= '{default: '0};
            r_wr_ptr  <= '0;
            r_cnt     <= '0;
            r_sum     <= '0;
            r_state   <= c_st_fill;
            r_z       <= '0;
            r_z_valid <= 1'b0;
        end else if (w_accept) begin
            r_buf[r_wr_ptr] <= X1;
            r_sum           <= w_sum_next;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
            r_z             <= w_quot;
            r_z_valid       <= (r_state == c_st_run) || w_fills;
            if (r_state == c_st_fill) begin
                r_cnt <= w_cnt_next;
                if (w_fills) begin
                    r_state <= c_st_run;
                end
            end
        end else begin
            r_z_valid <= 1'b0;
        end
    end

    assign Z       = r_z;
    assign Z_valid = r_z_valid;
    assign full    = (r_state == c_st_run);

endmodule
`default_nettype wire

// File: doc/moving_average_n.md
# moving_average_n

Parametrised moving-average filter: the successor to the fixed 8-bit `moving_average`, generalised in sample width and window depth. It adds a rounding mode, a running-sum datapath (constant cost per sample regardless of depth), warm-up tracking, an output-valid strobe and a synchronous window clear. It sits in the sample path between the input capture stage and downstream consumers, keeping the `enable_n` / `X1` / `Z` port convention so existing benches port directly.

## Interface
- `WIDTH`, 8, sample and result width in bits (unsigned)
- `LOG2_DEPTH`, 2, log2 of window length; DEPTH = 2**LOG2_DEPTH; legal range 1..8
- `ROUND`, 0, 0 = truncate quotient, 1 = round half up
- `Clk`  in  1  single clock, all logic on rising edge
- `Rst`  in  1  reset, synchronous, active-high
- `enable_n`  in  1  active-low sample strobe; `X1` accepted on an edge where `enable_n`=0
- `clear`  in  1  synchronous window flush, active-high
- `X1`  in  WIDTH  input sample
- `Z`  out  WIDTH  registered window average
- `Z_valid`  out  1  one-cycle pulse: `Z` holds a full-window average
- `full`  out  1  level: window holds DEPTH samples since last reset/clear

## Operation
- Storage: circular buffer of DEPTH×WIDTH, write pointer `wr_ptr` (LOG2_DEPTH bits, wraps DEPTH-1→0), fill counter `cnt` (0..DEPTH, LOG2_DEPTH+1 bits), running sum `sum` (WIDTH+LOG2_DEPTH bits).
- Two states: FILL (`cnt`<DEPTH) and RUN (`cnt`=DEPTH); `full` = (state==RUN).
- Accepted sample: old = buf[wr_ptr]; buf[wr_ptr] ← X1; sum_next = sum + X1 − old; wr_ptr ← wr_ptr+1; in FILL, cnt ← cnt+1, and FILL→RUN when cnt reaches DEPTH.
- Buffer entries are zero after reset/clear, so `sum` stays exact during FILL without special-casing.
- Quotient: ROUND=0 gives Z = sum_next >> LOG2_DEPTH; ROUND=1 gives Z = (sum_next + 2**(LOG2_DEPTH−1)) >> LOG2_DEPTH, computed at WIDTH+LOG2_DEPTH+1 bits. The result never exceeds 2**WIDTH−1, so no saturation logic is needed.
- In FILL, `Z` is still updated (a zero-padded average), but `Z_valid` stays low.
- `Z_valid` = 1 on the cycle after any accepted sample that leaves the window full, including the sample that completes the fill.
- No sample accepted (`enable_n`=1): all state and `Z` hold; `Z_valid` = 0.

## Timing
- Reset values (`Rst`=1 at edge): `Z`=0, `Z_valid`=0, `full`=0, `sum`=0, `cnt`=0, `wr_ptr`=0, all buffer entries 0.
- Latency: sample accepted at edge k → `Z`/`Z_valid` reflect it after edge k (1 cycle). Throughput is one sample per clock.
- Priority: `Rst` > `clear` > sample. `clear`=1 performs the full reset action; a sample presented in the same cycle is discarded, not stored.
- `Rst` or `clear` mid-window: partial or full window is discarded; the next accepted sample is treated as the first of a new window.
- Consecutive accepted samples produce back-to-back `Z_valid` pulses once in RUN.
- `X1` and `enable_n` are sampled only at the rising edge; no combinational path from input to output.

## Test plan
- Reset: hold `Rst` 2 cycles with `enable_n`=0 and `X1`=0xFF → `Z`=0, `Z_valid`=0, `full`=0; no sample stored.
- Warm-up (WIDTH=8, LOG2_DEPTH=2, ROUND=0): X1=2 for 4 consecutive cycles → `Z` = 0,1,1,2; `Z_valid` = 0,0,0,1; `full` rises with the 4th sample.
- Step plus pointer wrap: after the window is full of 2s, feed X1=10 for 4 cycles, then 2 for 4 cycles → `Z` = 4,6,8,10, then 8,6,4,2; `Z_valid` high on every sample.
- Extremes and rounding: X1=255×4 → `Z`=255 for both ROUND=0 and ROUND=1. After reset with ROUND=1, X1=1 then 2 → `Z` = 0, then 1 (truncate gives 0, 0).
- Gaps and clear: insert `enable_n`=1 gaps mid-window → `Z` holds and `Z_valid`=0 during gaps. Assert `clear` with `enable_n`=0 and X1=99 → `Z`=0, `full`=0, 99 discarded; the next 4 samples of 4 give `Z` = 1,2,3,4 with `Z_valid` only on the last.
- Depth sweep: LOG2_DEPTH=1 and 8 with a random stream → `Z` matches the reference-model window mean every cycle; `Z_valid` first asserts on sample DEPTH.
